// File: rtl/ff_shreg.sv
// Parameterised shift register with addressable tap, saturating fill count and synchronous reset/set.
// D reaches TAP after SEL+1 enabled edges and CQZ after DEPTH; no backpressure, QEN alone gates shifting.
module ff_shreg #(
   parameter  int               WIDTH = 1,
   parameter  int               DEPTH = 4,
   parameter  logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
   localparam int               AW    = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
   localparam int               FW    = $clog2(DEPTH + 1)
) (
   (* clkbuf_sink *) input  logic             QCK,
   (* clkbuf_sink *) input  logic             QRT,
   (* clkbuf_sink *) input  logic             QST,
   input  logic             QEN,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    SEL,
   output logic [WIDTH-1:0] TAP,
   output logic [WIDTH-1:0] CQZ,
   output logic [FW-1:0]    FILL,
   output logic             FULL
);

   // Declaration initialisers give the power-up contents; no reset is needed to reach them.
   logic [WIDTH-1:0] r_stage [DEPTH] = '{default: INIT};
   logic [FW-1:0]    r_fill          = '0;
   logic [WIDTH-1:0] w_tap;

   always_ff @(posedge QCK) begin
      if (QRT) begin
         r_stage <= '{default: '0};
         r_fill  <= '0;
      end else if (QST) begin
         r_stage <= '{default: '1};
         r_fill  <= FW'(DEPTH);
      end else if (QEN) begin
         r_stage[0] <= D;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
         if (r_fill != FW'(DEPTH)) begin
            r_fill <= r_fill + FW'(1);
         end
      end
   end

   // Addresses at or beyond DEPTH match no stage and read as zero.
   always_comb begin
      w_tap = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (SEL == AW'(i)) begin
            w_tap = r_stage[i];
         end
      end
   end

   assign TAP  = w_tap;
   assign CQZ  = r_stage[DEPTH-1];
   assign FILL = r_fill;
   assign FULL = (r_fill == FW'(DEPTH));

endmodule

// File: tb/tb_ff_shreg.sv
// Bench for ff_shreg: vector table, corner-case sequences and randomised run against a queue model.
module tb_ff_shreg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: WIDTH=8, DEPTH=4, INIT=0
   logic       qrt = 1'b0, qst = 1'b0, qen = 1'b0;
   logic [7:0] d = 8'h00;
   logic [1:0] sel = 2'd0;
   logic [7:0] tap, cqz;
   logic [2:0] fill;
   logic       full;

   // DEPTH=3 instance
   logic       d3_rt = 1'b1, d3_en = 1'b0;
   logic [7:0] d3_d = 8'h00;
   logic [1:0] d3_sel = 2'd0;
   logic [7:0] d3_tap, d3_cqz;
   logic [1:0] d3_fill;
   logic       d3_full;

   // INIT=0xA5 instance, never reset
   logic       in_en = 1'b0;
   logic [7:0] in_d = 8'h00;
   logic [7:0] in_tap, in_cqz;
   logic [2:0] in_fill;
   logic       in_full;

   ff_shreg #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) u_dut (
      .QCK(clk), .QRT(qrt), .QST(qst), .QEN(qen), .D(d), .SEL(sel),
      .TAP(tap), .CQZ(cqz), .FILL(fill), .FULL(full));

   ff_shreg #(.WIDTH(8), .DEPTH(3), .INIT(8'h00)) u_d3 (
      .QCK(clk), .QRT(d3_rt), .QST(1'b0), .QEN(d3_en), .D(d3_d), .SEL(d3_sel),
      .TAP(d3_tap), .CQZ(d3_cqz), .FILL(d3_fill), .FULL(d3_full));

   ff_shreg #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u_init (
      .QCK(clk), .QRT(1'b0), .QST(1'b0), .QEN(in_en), .D(in_d), .SEL(2'd0),
      .TAP(in_tap), .CQZ(in_cqz), .FILL(in_fill), .FULL(in_full));

   typedef struct {
      logic       rt, st, en;
      logic [7:0] d;
      logic [1:0] sel;
      logic [7:0] cqz, tap;
      logic [2:0] fill;
      logic       full;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      qrt = v.rt; qst = v.st; qen = v.en; d = v.d; sel = v.sel;
      @(posedge clk);
      #1;
      chk({tag, ".cqz"},  32'(cqz),  32'(v.cqz));
      chk({tag, ".tap"},  32'(tap),  32'(v.tap));
      chk({tag, ".fill"}, 32'(fill), 32'(v.fill));
      chk({tag, ".full"}, 32'(full), 32'(v.full));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   vec_t       vt [12];
   logic [7:0] m_q [$];
   int         m_fill;
   vec_t       rv;

   initial begin
      vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, 3'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h11, 2'd0, 8'h00, 8'h11, 3'd1, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 8'h22, 2'd1, 8'h00, 8'h11, 3'd2, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b1, 8'h33, 2'd2, 8'h00, 8'h11, 3'd3, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h44, 2'd0, 8'h11, 8'h44, 3'd4, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h55, 2'd3, 8'h22, 8'h22, 3'd4, 1'b1};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 8'hAA, 2'd3, 8'h22, 8'h22, 3'd4, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 8'hBB, 2'd0, 8'h22, 8'h55, 3'd4, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 8'hCC, 2'd1, 8'h22, 8'h44, 3'd4, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 2'd2, 8'h00, 8'h00, 3'd0, 1'b0};
      vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 8'hFF, 8'hFF, 3'd4, 1'b1};
      vt[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd3, 8'h00, 8'h00, 3'd0, 1'b0};

      // Power-up values before any edge
      #1;
      chk("pwrup.init_cqz",  32'(in_cqz),  32'h A5);
      chk("pwrup.init_fill", 32'(in_fill), 32'd0);
      chk("pwrup.init_full", 32'(in_full), 32'd0);
      chk("pwrup.main_cqz",  32'(cqz),     32'd0);
      chk("pwrup.main_fill", 32'(fill),    32'd0);

      // First shift of the un-reset INIT instance
      in_en = 1'b1; in_d = 8'h3C;
      @(posedge clk);
      #1;
      in_en = 1'b0;
      chk("init.first_fill", 32'(in_fill), 32'd1);
      chk("init.first_cqz",  32'(in_cqz),  32'h A5);
      chk("init.first_tap",  32'(in_tap),  32'h 3C);

      for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("vec%0d", i));

      // Every tap reads zero after reset
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("rst.tap_sel%0d", s), 32'(tap), 32'd0);
      end

      // Reset/set pulses that fall entirely between edges
      apply('{1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 8'h00, 8'h5A, 3'd1, 1'b0}, "pulse.ld0");
      apply('{1'b0, 1'b0, 1'b1, 8'h6B, 2'd1, 8'h00, 8'h5A, 3'd2, 1'b0}, "pulse.ld1");
      @(negedge clk);
      qen = 1'b0;
      #1 qrt = 1'b1; qst = 1'b1;
      #2 qrt = 1'b0; qst = 1'b0;
      @(posedge clk);
      #1;
      chk("pulse.tap",  32'(tap),  32'h 5A);
      chk("pulse.fill", 32'(fill), 32'd2);
      chk("pulse.cqz",  32'(cqz),  32'd0);
      sel = 2'd0;
      #1;
      chk("pulse.tap0", 32'(tap),  32'h 6B);

      // DEPTH=3: out-of-range tap address
      @(negedge clk);
      d3_rt = 1'b0; d3_en = 1'b1; d3_d = 8'hA1;
      @(negedge clk);
      d3_d = 8'hB2;
      @(negedge clk);
      d3_d = 8'hC3;
      @(negedge clk);
      d3_en = 1'b0; d3_sel = 2'd3;
      #1;
      chk("d3.tap_sel3", 32'(d3_tap),  32'd0);
      chk("d3.fill",     32'(d3_fill), 32'd3);
      chk("d3.full",     32'(d3_full), 32'd1);
      chk("d3.cqz",      32'(d3_cqz),  32'h A1);
      d3_sel = 2'd2;
      #1;
      chk("d3.tap_sel2", 32'(d3_tap),  32'h A1);
      d3_sel = 2'd0;
      #1;
      chk("d3.tap_sel0", 32'(d3_tap),  32'h C3);

      // Randomised run against a queue model; the first step always resets
      m_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      m_fill = 0;
      for (int n = 0; n < 300; n++) begin
         rv.rt  = (n == 0) || ($urandom % 16 == 0);
         rv.st  = ($urandom % 16 == 0);
         rv.en  = $urandom % 2;
         rv.d   = 8'($urandom);
         rv.sel = 2'($urandom % 4);
         if (rv.rt) begin
            m_q = '{8'h00, 8'h00, 8'h00, 8'h00};
            m_fill = 0;
         end else if (rv.st) begin
            m_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
            m_fill = 4;
         end else if (rv.en) begin
            m_q.push_front(rv.d);
            void'(m_q.pop_back());
            if (m_fill < 4) m_fill++;
         end
         rv.cqz  = m_q[3];
         rv.tap  = m_q[rv.sel];
         rv.fill = 3'(m_fill);
         rv.full = (m_fill == 4);
         apply(rv, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ff_shreg.md
FF_SHREG -- requirements
Module: ff_shreg

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 1, bits per stage (>=1)
- DEPTH, 4, number of stages (>=2)
- INIT, {WIDTH{1'b0}}, power-up value of every stage
REQ-002 Localparam AW SHALL equal max(1, clog2(DEPTH)); FW SHALL equal clog2(DEPTH+1).
REQ-003 Ports SHALL be, one per line:
- QCK, input, 1, clock, rising edge; clkbuf_sink
- QRT, input, 1, reset, synchronous, active-high; clkbuf_sink
- QST, input, 1, set, synchronous, active-high; clkbuf_sink
- QEN, input, 1, shift enable
- D, input, WIDTH, serial data into stage 0
- SEL, input, AW, tap address
- TAP, output, WIDTH, contents of stage[SEL]
- CQZ, output, WIDTH, contents of stage[DEPTH-1]
- FILL, output, FW, count of valid stages
- FULL, output, 1, FILL==DEPTH
REQ-004 The block SHALL have one clock (QCK); reset SHALL be synchronous and active-high (QRT).

Function
REQ-005 State SHALL be DEPTH registers stage[0..DEPTH-1] of WIDTH bits plus the FILL counter; all updates SHALL occur on the QCK rising edge only.
REQ-006 Per-edge priority SHALL be QRT > QST > QEN > hold.
REQ-007 QST=1 (QRT=0) SHALL load every stage with all-ones and set FILL=DEPTH on that edge.
REQ-008 QEN=1 (QRT=0, QST=0) SHALL shift: stage[0]<=D, stage[i]<=stage[i-1] for i=1..DEPTH-1, one position per edge.
REQ-009 QEN=0 with QRT=0 and QST=0 SHALL hold all stages and FILL unchanged.
REQ-010 FILL SHALL increment by 1 on each shift edge, saturate at DEPTH, and never wrap.
REQ-011 FULL SHALL be combinational from FILL, asserted exactly when FILL==DEPTH.
REQ-012 CQZ SHALL be stage[DEPTH-1] with no added register; latency D->CQZ SHALL be DEPTH enabled edges.
REQ-013 TAP SHALL be combinational from SEL and the stages: stage[SEL] when SEL<DEPTH, all-zero when SEL>=DEPTH (non-power-of-2 DEPTH).
REQ-014 Latency D->TAP SHALL be SEL+1 enabled edges.
REQ-015 Shifting while FULL SHALL discard the old stage[DEPTH-1] value; FILL SHALL remain DEPTH.
REQ-016 The block SHALL contain no asynchronous paths from QRT or QST; an input pulse between edges SHALL have no effect.

Reset
REQ-017 At power-up (initial), every stage SHALL equal INIT and FILL SHALL be 0.
REQ-018 QRT=1 at an edge SHALL clear every stage to 0 and FILL to 0, regardless of QST, QEN and D.
REQ-019 QRT asserted mid-shift SHALL abort the shift, with no partial update of any stage.
REQ-020 After reset, CQZ=0, TAP=0 for all SEL, FILL=0 and FULL=0.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-021 Reset, then shift 0x11, 0x22, 0x33, 0x44 with QEN=1 -> CQZ=0x11, TAP(SEL=0)=0x44, FILL=4, FULL=1; each intermediate FILL is 1, 2, 3.
REQ-022 FULL, then shift 0x55 -> CQZ=0x22, FILL stays 4; then QEN=0 for 3 edges with D changing -> all outputs unchanged.
REQ-023 QRT=1, QST=1, QEN=1 on the same edge -> all stages 0x00, FILL=0; next edge QST=1 only -> all stages 0xFF, FILL=4.
REQ-024 QRT pulsed high between edges and low at each edge -> no state change.
REQ-025 DEPTH=3, SEL=3 -> TAP=0x00 while stages hold nonzero data; SEL=2 -> TAP=stage[2].
REQ-026 INIT=0xA5, no reset applied -> CQZ=0xA5 and FILL=0 at time 0; the first shift edge gives FILL=1.
